// File: rtl/matrix_packer.sv
// matrix_packer: assembles a serial element stream into a registered,
// flattened N x N matrix and holds it under a valid/ready handshake.
// Element (i,j) sits at mat_out[N*N*W-(N*i+j)*W-1 -: W]; (0,0) is in the MSBs.
// Optional build macro: MATRIX_PACKER_COLMAJOR_EN selects a column-major
// input stream (row advances first), which lands a row-major source transposed.
module matrix_packer #(
  parameter int unsigned MATRIX_SIZE = 4,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            flush,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mat_out,
  output logic                                            mat_valid,
  input  logic                                            mat_ready,
  output logic [$clog2(MATRIX_SIZE*MATRIX_SIZE+1)-1:0]    elem_count
);

  localparam int unsigned N  = MATRIX_SIZE;
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned NN = N * N;
  localparam int unsigned MW = NN * W;
  localparam int unsigned CW = $clog2(NN + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   row_q, row_d;
  logic [IW-1:0]   col_q, col_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            last_slot;
  logic [SW-1:0]   slot;
  logic [W-1:0]    elem_q [NN];

  // Flat slot index of the current (row,col) write position.
  assign slot = SW'(row_q) * SW'(N) + SW'(col_q);

  // State, position and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  // Element storage; slots are overwritten in place, never cleared on handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NN); k++) begin
        elem_q[k] <= '0;
      end
    end else if (accept) begin
      elem_q[slot] <= in_data;
    end
  end

  // Next-state, position advance and handshake decode; flush overrides all.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == FILL) && !flush;
    accept    = in_valid && in_ready;
    last_slot = (row_q == IW'(N - 1)) && (col_q == IW'(N - 1));

    if (flush) begin
      state_d = FILL;
      row_d   = '0;
      col_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            cnt_d = cnt_q + CW'(1);
`ifdef MATRIX_PACKER_COLMAJOR_EN
            if (row_q == IW'(N - 1)) begin
              row_d = '0;
              col_d = col_q + IW'(1);
            end else begin
              row_d = row_q + IW'(1);
            end
`else
            if (col_q == IW'(N - 1)) begin
              col_d = '0;
              row_d = row_q + IW'(1);
            end else begin
              col_d = col_q + IW'(1);
            end
`endif
            if (last_slot) begin
              state_d = HOLD;
              row_d   = '0;
              col_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        HOLD: begin
          if (mat_ready) begin
            state_d = FILL;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  // mat_valid is the state flop itself, so it has no path from mat_ready.
  assign mat_valid  = (state_q == HOLD);
  assign elem_count = cnt_q;

  // Flatten storage with slot 0 in the MSBs.
  for (genvar k = 0; k < int'(NN); k++) begin : g_pack
    assign mat_out[MW-1-k*W -: W] = elem_q[k];
  end

endmodule

// File: tb/tb_matrix_packer.sv
// Scoreboard bench for matrix_packer (N=4, W=8): directed scenarios followed by
// randomized traffic. A stream-index reference model predicts handshakes and
// complete matrices; a negedge monitor compares whatever the DUT presents.
module tb_matrix_packer;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned NN = N * N;
  localparam int unsigned MW = NN * W;
  localparam int unsigned CW = $clog2(NN + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          mat_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          mat_valid;
  logic [MW-1:0] mat_out;
  logic [CW-1:0] elem_count;

  int chk_cnt = 0;
  int pass_cnt = 0;

  matrix_packer #(.MATRIX_SIZE(N), .DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mat_out    (mat_out),
    .mat_valid  (mat_valid),
    .mat_ready  (mat_ready),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (stream-index based) ----------------
  logic [W-1:0]  m_el [NN];
  bit            m_hold = 1'b0;
  int            m_cnt = 0;
  logic [MW-1:0] exp_q [$];
  int            n_pres = 0;

  initial foreach (m_el[k]) m_el[k] = '0;

  // Stream element k lands in flat slot row*N+col.
  function automatic int slot_of(input int k);
`ifdef MATRIX_PACKER_COLMAJOR_EN
    return (k % N) * N + (k / N);
`else
    return k;
`endif
  endfunction

  function automatic logic [MW-1:0] pack_model();
    logic [MW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NN); k++) v[MW-1-k*W -: W] = m_el[k];
    return v;
  endfunction

  // Independent directed expectation: stream base+idx, idx by fill order.
  function automatic logic [MW-1:0] stream_exp(input int base);
    logic [MW-1:0] v;
    int idx;
    v = '0;
    for (int i = 0; i < int'(N); i++)
      for (int j = 0; j < int'(N); j++) begin
`ifdef MATRIX_PACKER_COLMAJOR_EN
        idx = j * N + i;
`else
        idx = i * N + j;
`endif
        v[MW-1-(i*N+j)*W -: W] = W'(base + idx);
      end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b0;
      m_cnt  = 0;
      foreach (m_el[k]) m_el[k] = '0;
      exp_q.delete();
    end else if (flush) begin
      m_hold = 1'b0;
      m_cnt  = 0;
    end else if (m_hold) begin
      if (mat_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      m_el[slot_of(m_cnt)] = in_data;
      m_cnt++;
      if (m_cnt == int'(NN)) begin
        m_cnt  = 0;
        m_hold = 1'b1;
        exp_q.push_back(pack_model());
      end
    end
  end

  // ---------------- monitor ----------------
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [MW-1:0] prev_out = '0;

  always @(negedge clk) begin
    check("in_ready", MW'(in_ready), MW'(!m_hold && !flush));
    check("mat_valid", MW'(mat_valid), MW'(m_hold));
    check("elem_count", MW'(elem_count), MW'(m_hold ? 0 : m_cnt));
    check("ready_valid_exclusive", MW'(in_ready & mat_valid), '0);
    if (mat_valid && prev_valid && !prev_ready)
      check("hold_stable", mat_out, prev_out);
    if (mat_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_matrix: got %h expected none at %0t", mat_out, $time);
      end else begin
        check("matrix", mat_out, exp_q.pop_front());
        n_pres++;
      end
    end
    prev_valid = mat_valid && rst_n;
    prev_ready = mat_ready;
    prev_out   = mat_out;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    mat_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mat_valid"}, MW'(mat_valid), '0);
    check({tag, "_mat_out"}, mat_out, '0);
    check({tag, "_in_ready"}, MW'(in_ready), MW'(1));
    check({tag, "_elem_count"}, MW'(elem_count), '0);
  endtask

  initial begin
    logic [MW-1:0] first_exp;
    int target;
    int cycles;

`ifdef MATRIX_PACKER_COLMAJOR_EN
    first_exp = 128'h0004080C_0105090D_02060A0E_03070B0F;
`else
    first_exp = 128'h00010203_04050607_08090A0B_0C0D0E0F;
`endif

    #1 rst_n = 1'b0;
    #1 check_reset_values("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Full matrix at one element per cycle, then hold 10 cycles.
    for (int k = 0; k < 16; k++) drive(1'b1, W'(k), 1'b0, 1'b0);
    check("latency_valid", MW'(mat_valid), MW'(1));
    for (int k = 0; k < 10; k++) drive(1'b0, '0, 1'b0, 1'b0);
    check("mat1", mat_out, first_exp);
    check("hold_in_ready", MW'(in_ready), '0);

    // Handoff pulse, then the next matrix right away.
    drive(1'b0, '0, 1'b1, 1'b0);
    check("handoff_valid", MW'(mat_valid), '0);
    check("handoff_in_ready", MW'(in_ready), MW'(1));
    for (int k = 0; k < 16; k++) drive(1'b1, W'(8'hF0 + k), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("mat2", mat_out, stream_exp(8'hF0));

    // Partial fill, flush with a valid element, then a fresh matrix.
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) drive(1'b1, W'(8'h10 + k), 1'b0, 1'b0);
    check("partial_count", MW'(elem_count), MW'(7));
    drive(1'b1, 8'h99, 1'b0, 1'b1);
    check("flush_count", MW'(elem_count), '0);
    for (int k = 0; k < 16; k++) drive(1'b1, W'(8'h20 + k), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("mat3", mat_out, stream_exp(8'h20));
    check("mat3_valid", MW'(mat_valid), MW'(1));

    // Asynchronous reset while holding.
    rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic until 20 more matrices have been presented.
    target = n_pres + 20;
    cycles = 0;
    while (n_pres < target && cycles < 4000) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0));
      cycles++;
    end
    if (n_pres < target) begin
      chk_cnt++;
      $display("FAIL random_timeout: got %0d matrices expected %0d", n_pres, target);
    end

    for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, 1'b0);
    check("scoreboard_drained", MW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
